// File: rtl/multi_dataflow_uloop_pkg.sv
// multi_dataflow_package: shared types, defaults and stream indices for the micro-loop offset generator.
package multi_dataflow_package;
    localparam int unsigned NB_LOOPS = 3;
    localparam int unsigned NB_STREAMS = 3;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned OFFS_W = 32;
    localparam int unsigned UCODE_IN_PEL_OFFS = 0;
    localparam int unsigned UCODE_IN_SIZE_OFFS = 1;
    localparam int unsigned UCODE_OUT_PEL_OFFS = 2;

    typedef struct packed {
        logic enable;
        logic clear;
    } ctrl_uloop_t;

    typedef struct packed {
        logic [NB_LOOPS-1:0][CNT_W-1:0] range;
        logic [NB_LOOPS-1:0][NB_STREAMS-1:0][OFFS_W-1:0] stride;
    } cfg_uloop_t;

    typedef struct packed {
        logic [NB_STREAMS-1:0][OFFS_W-1:0] offs;
        logic [NB_LOOPS-1:0][CNT_W-1:0] idx;
        logic valid;
        logic done;
    } flags_uloop_t;

    typedef enum logic {ULOOP_READY, ULOOP_UPDATE} uloop_state_t;
endpackage

// File: rtl/multi_dataflow_uloop_acc.sv
// multi_dataflow_uloop_acc: one loop level's offset accumulators across all streams.
module multi_dataflow_uloop_acc #(
    parameter int unsigned NB_STREAMS = 3,
    parameter int unsigned OFFS_W = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clr,
    input  logic                                add,
    input  logic                                load,
    input  logic [NB_STREAMS-1:0][OFFS_W-1:0]   stride,
    input  logic [NB_STREAMS-1:0][OFFS_W-1:0]   load_val,
    output logic [NB_STREAMS-1:0][OFFS_W-1:0]   acc,
    output logic [NB_STREAMS-1:0][OFFS_W-1:0]   sum
);
    always_comb begin
        sum = '0;
        for (int s = 0; s < NB_STREAMS; s++) sum[s] = acc[s] + stride[s];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) acc <= '0;
        else if (clr) acc <= '0;
        else if (add) acc <= sum;
        else if (load) acc <= load_val;
    end
endmodule

// File: rtl/multi_dataflow_uloop.sv
// multi_dataflow_uloop: nested micro-loop offset generator feeding the controller FSM.
// MULTI_DATAFLOW_ULOOP_FAST_EN resolves every advance in one UPDATE cycle via a priority encoder.
module multi_dataflow_uloop #(
    parameter int unsigned NB_LOOPS = multi_dataflow_package::NB_LOOPS,
    parameter int unsigned NB_STREAMS = multi_dataflow_package::NB_STREAMS,
    parameter int unsigned CNT_W = multi_dataflow_package::CNT_W,
    parameter int unsigned OFFS_W = multi_dataflow_package::OFFS_W
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 test_mode_i,
    input  logic                                 clear_i,
    input  multi_dataflow_package::ctrl_uloop_t  ctrl_i,
    input  multi_dataflow_package::cfg_uloop_t   cfg_i,
    output multi_dataflow_package::flags_uloop_t flags_o
);
    import multi_dataflow_package::*;

    localparam int unsigned LW = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;

    uloop_state_t state;
    logic [LW-1:0] lvl, cur;
    logic [NB_LOOPS-1:0][CNT_W-1:0] idx;
    logic [NB_LOOPS-1:0] at_max, add, load;
    logic [NB_LOOPS-1:0][NB_STREAMS-1:0][OFFS_W-1:0] acc, sum;
    logic [NB_STREAMS-1:0][OFFS_W-1:0] nxt;
    logic valid, done, clr, adv, unused_test;

    assign unused_test = test_mode_i;
    assign clr = clear_i | ctrl_i.clear;

    // A zero range behaves as range 1, so its last index is 0.
    always_comb begin
        at_max = '0;
        for (int l = 0; l < NB_LOOPS; l++)
            at_max[l] = idx[l] == cfg_i.range[l] - CNT_W'(cfg_i.range[l] != '0);
    end

`ifdef MULTI_DATAFLOW_ULOOP_FAST_EN
    always_comb begin
        cur = '0;
        for (int l = NB_LOOPS - 1; l >= 0; l--) if (!at_max[l]) cur = LW'(l);
    end
`else
    assign cur = lvl;
`endif

    assign adv = (state == ULOOP_UPDATE) && !at_max[cur] && !clr;
    assign nxt = sum[cur];

    always_comb begin
        add = '0;
        load = '0;
        for (int l = 0; l < NB_LOOPS; l++) begin
            add[l] = adv && (cur == LW'(l));
            load[l] = adv && (LW'(l) < cur);
        end
    end

    for (genvar l = 0; l < NB_LOOPS; l++) begin : g_acc
        multi_dataflow_uloop_acc #(.NB_STREAMS(NB_STREAMS), .OFFS_W(OFFS_W)) i_acc (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr      (clr),
            .add      (add[l]),
            .load     (load[l]),
            .stride   (cfg_i.stride[l]),
            .load_val (nxt),
            .acc      (acc[l]),
            .sum      (sum[l])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ULOOP_READY;
            lvl <= '0;
            idx <= '0;
            valid <= 1'b1;
            done <= 1'b0;
        end else if (clr) begin
            state <= ULOOP_READY;
            lvl <= '0;
            idx <= '0;
            valid <= 1'b1;
            done <= 1'b0;
        end else if (state == ULOOP_READY) begin
            if (ctrl_i.enable) begin
                if (&at_max) done <= 1'b1;
                else begin
                    state <= ULOOP_UPDATE;
                    lvl <= '0;
                    valid <= 1'b0;
                end
            end
        end else begin
            for (int l = 0; l < NB_LOOPS; l++) if (LW'(l) < cur) idx[l] <= '0;
            if (!at_max[cur]) begin
                idx[cur] <= idx[cur] + 1'b1;
                state <= ULOOP_READY;
                valid <= 1'b1;
            end else begin
                idx[cur] <= '0;
                lvl <= lvl + 1'b1;
            end
        end
    end

    assign flags_o.offs = acc[0];
    assign flags_o.idx = idx;
    assign flags_o.valid = valid;
    assign flags_o.done = done;
endmodule

// File: tb/tb_multi_dataflow_uloop.sv
// tb_multi_dataflow_uloop: directed and random checks of the micro-loop generator against an index-level model.
module tb_multi_dataflow_uloop;
    import multi_dataflow_package::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    logic test_mode = 1'b0;
    logic clear = 1'b0;
    ctrl_uloop_t ctrl = '0;
    cfg_uloop_t cfg = '0;
    flags_uloop_t flags;

    int n_assert = 0;
    int n_fail = 0;
    int m_idx[NB_LOOPS];
    bit m_done;

    multi_dataflow_uloop dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode),
        .clear_i     (clear),
        .ctrl_i      (ctrl),
        .cfg_i       (cfg),
        .flags_o     (flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rng(input int l);
        return (cfg.range[l] == 0) ? 1 : int'(cfg.range[l]);
    endfunction

    function automatic logic [OFFS_W-1:0] m_offs(input int s);
        logic [63:0] t = 0;
        for (int l = 0; l < NB_LOOPS; l++) t += 64'(m_idx[l]) * 64'(cfg.stride[l][s]);
        return t[OFFS_W-1:0];
    endfunction

    // Returns the level that increments, or -1 when the nest is exhausted.
    function automatic int m_adv();
        for (int l = 0; l < NB_LOOPS; l++) begin
            if (m_idx[l] < rng(l) - 1) begin
                m_idx[l]++;
                for (int k = 0; k < l; k++) m_idx[k] = 0;
                return l;
            end
        end
        m_done = 1;
        return -1;
    endfunction

    task automatic check_state(input string tag);
        for (int s = 0; s < NB_STREAMS; s++) chk($sformatf("%s_offs%0d", tag, s), 64'(flags.offs[s]), 64'(m_offs(s)));
        for (int l = 0; l < NB_LOOPS; l++) chk($sformatf("%s_idx%0d", tag, l), 64'(flags.idx[l]), 64'(m_idx[l]));
        chk({tag, "_valid"}, 64'(flags.valid), 64'd1);
        chk({tag, "_done"}, 64'(flags.done), 64'(m_done));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        foreach (m_idx[l]) m_idx[l] = 0;
        m_done = 0;
    endtask

    task automatic do_enable(input string tag);
        int j, lat, exp_lat;
        ctrl.enable = 1'b1;
        step();
        ctrl.enable = 1'b0;
        j = m_adv();
        if (j < 0) begin
            chk({tag, "_done_valid"}, 64'(flags.valid), 64'd1);
        end else begin
            chk({tag, "_drop"}, 64'(flags.valid), 64'd0);
            lat = 0;
            while (flags.valid !== 1'b1 && lat < 20) begin
                lat++;
                step();
            end
`ifdef MULTI_DATAFLOW_ULOOP_FAST_EN
            exp_lat = 1;
`else
            exp_lat = j + 1;
`endif
            chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        end
        check_state(tag);
    endtask

    initial begin
        int exp_nest[5] = '{4, 16, 20, 32, 36};
        int adv_cnt, total;
        bit prev_v;
        #2 rst_ni = 1'b0;
        #1;
        foreach (m_idx[l]) m_idx[l] = 0;
        m_done = 0;
        check_state("reset");
        step();
        rst_ni = 1'b1;
        step();

        // Nest {2,3,1}, in_pel strides {4,16,0}
        cfg = '0;
        cfg.range[0] = 2; cfg.range[1] = 3; cfg.range[2] = 1;
        cfg.stride[0][UCODE_IN_PEL_OFFS] = 4;
        cfg.stride[1][UCODE_IN_PEL_OFFS] = 16;
        cfg.stride[0][UCODE_OUT_PEL_OFFS] = 32'h100;
        cfg.stride[1][UCODE_IN_SIZE_OFFS] = 32'h7;
        do_clear();
        check_state("nest0");
        for (int i = 0; i < 5; i++) begin
            do_enable($sformatf("nest%0d", i + 1));
            chk($sformatf("nest_const%0d", i + 1), 64'(flags.offs[UCODE_IN_PEL_OFFS]), 64'(exp_nest[i]));
        end
        chk("nest_end_idx", 64'({flags.idx[2], flags.idx[1], flags.idx[0]}), {16'd0, 16'd0, 16'd2, 16'd1});
        do_enable("nest_done");
        chk("nest_done_offs", 64'(flags.offs[UCODE_IN_PEL_OFFS]), 64'd36);
        do_enable("nest_noop");

        // Clear during a level-1 scan
        do_clear();
        do_enable("clr_pre");
        ctrl.enable = 1'b1;
        step();
        ctrl.enable = 1'b0;
        ctrl.clear = 1'b1;
        step();
        ctrl.clear = 1'b0;
        foreach (m_idx[l]) m_idx[l] = 0;
        m_done = 0;
        check_state("clr_mid");
        step();
        check_state("clr_mid_hold");

        // Clear and enable together
        do_enable("ce_pre");
        ctrl = '{enable: 1'b1, clear: 1'b1};
        step();
        ctrl = '0;
        foreach (m_idx[l]) m_idx[l] = 0;
        check_state("clr_en");
        step();
        check_state("clr_en_hold");

        // Degenerate ranges
        cfg.range = '0;
        do_clear();
        do_enable("degen");
        step();
        check_state("degen_hold");

        // Negative stride wrap
        cfg = '0;
        cfg.range[0] = 3;
        cfg.stride[0][UCODE_IN_PEL_OFFS] = 32'hFFFF_FFFC;
        do_clear();
        do_enable("wrap1");
        do_enable("wrap2");
        chk("wrap_const", 64'(flags.offs[UCODE_IN_PEL_OFFS]), 64'hFFFF_FFF8);

        // Enable held high through UPDATE
        cfg.range[0] = 3; cfg.range[1] = 2; cfg.range[2] = 2;
        for (int l = 0; l < NB_LOOPS; l++)
            for (int s = 0; s < NB_STREAMS; s++) cfg.stride[l][s] = $urandom;
        do_clear();
        total = 12;
        adv_cnt = 0;
        prev_v = 1'b1;
        ctrl.enable = 1'b1;
        for (int c = 0; c < 200 && flags.done !== 1'b1; c++) begin
            step();
            if (flags.valid === 1'b1 && !prev_v) begin
                void'(m_adv());
                check_state($sformatf("hold%0d", adv_cnt));
                adv_cnt++;
            end
            prev_v = flags.valid;
        end
        ctrl.enable = 1'b0;
        chk("hold_count", 64'(adv_cnt), 64'(total - 1));
        chk("hold_done", 64'(flags.done), 64'd1);

        // Random nests walked to completion
        for (int t = 0; t < 6; t++) begin
            for (int l = 0; l < NB_LOOPS; l++) begin
                cfg.range[l] = CNT_W'($urandom_range(0, 4));
                for (int s = 0; s < NB_STREAMS; s++) cfg.stride[l][s] = $urandom;
            end
            do_clear();
            check_state($sformatf("rnd%0d_start", t));
            for (int e = 0; e < 70 && !m_done; e++) do_enable($sformatf("rnd%0d_e%0d", t, e));
            do_enable($sformatf("rnd%0d_after", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
